hot_chan_mask: RTL

//  Input stage directly upstream of the chamber one-shot stage. Registers the raw
//  6x64 anode-wire hits and ANDs each wire with a hot-channel mask bit, so noisy wires

---
 rtl/alct_pkg.sv | 31 +++
 rtl/hcm_loader.sv | 87 ++++++++
 rtl/hot_chan_mask.sv | 73 +++++++
 3 files changed

// File: rtl/alct_pkg.sv
// Shared constants and FSM encoding for the chamber input stage.
// The mask length is derived from the chamber geometry and is not a free parameter.
package alct_pkg;

    localparam int NW    = 64;
    localparam int NL    = 6;
    localparam int MBITS = NW * NL;
    localparam int CW    = 9;

    localparam logic [CW-1:0] CNT_ZERO = 9'd0;
    localparam logic [CW-1:0] CNT_FULL = 9'd384;
    localparam logic [CW-1:0] CNT_OVR  = 9'd385;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    // Counter step that parks at MBITS+1 so an overrun stays recognisable.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        if (c >= CNT_OVR) begin
            r = CNT_OVR;
        end else begin
            r = c + 9'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hcm_loader.sv
// Serial mask loader: staging shift register, bit counter, IDLE/LOAD/DONE FSM and
// sticky error flag. commit_ok is high in the cycle a valid commit is accepted.
module hcm_loader
    import alct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdi,
    input  logic             shift,
    input  logic             commit,
    input  logic             err_clr,
    output logic [MBITS-1:0] staging,
    output logic             commit_ok,
    output logic             busy,
    output logic             err,
    output logic             sdo
);

    ld_state_t        state_r;
    ld_state_t        state_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [CW-1:0]    count_inc_s;
    logic [MBITS-1:0] staging_r;
    logic [MBITS-1:0] staging_nxt_s;
    logic             err_r;
    logic             err_set_s;
    logic             commit_ok_s;

    // Next-state decode; a commit always wins over a shift in the same cycle.
    always_comb begin
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        staging_nxt_s = staging_r;
        err_set_s     = 1'b0;
        commit_ok_s   = 1'b0;
        count_inc_s   = cnt_inc(count_r);
        if (commit) begin
            count_nxt_s = CNT_ZERO;
            state_nxt_s = ST_IDLE;
            case (state_r)
                ST_DONE: commit_ok_s = 1'b1;
                ST_IDLE: err_set_s   = 1'b1;
                ST_LOAD: err_set_s   = 1'b1;
                default: err_set_s   = 1'b1;
            endcase
        end else if (shift) begin
            staging_nxt_s = {sdi, staging_r[MBITS-1:1]};
            count_nxt_s   = count_inc_s;
            if (count_inc_s == CNT_FULL) begin
                state_nxt_s = ST_DONE;
            end else begin
                state_nxt_s = ST_LOAD;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Loader state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            staging_r <= {MBITS{1'b1}};
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            staging_r <= staging_nxt_s;
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign staging   = staging_r;
    assign commit_ok = commit_ok_s;
    assign busy      = (state_r != ST_IDLE);
    assign err       = err_r;
    assign sdo       = staging_r[0];

endmodule

// File: rtl/hot_chan_mask.sv
// Registers raw anode hits and gates each wire with its hot-channel mask bit.
// The active mask is replaced atomically from the loader's staging bus on commit.
module hot_chan_mask
    import alct_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NW-1:0] ly0,
    input  logic [NW-1:0] ly1,
    input  logic [NW-1:0] ly2,
    input  logic [NW-1:0] ly3,
    input  logic [NW-1:0] ly4,
    input  logic [NW-1:0] ly5,
    output logic [NW-1:0] lym0,
    output logic [NW-1:0] lym1,
    output logic [NW-1:0] lym2,
    output logic [NW-1:0] lym3,
    output logic [NW-1:0] lym4,
    output logic [NW-1:0] lym5,
    input  logic          mask_sdi,
    input  logic          mask_shift,
    input  logic          mask_commit,
    output logic          mask_sdo,
    output logic          mask_busy,
    output logic          mask_err,
    input  logic          err_clr
);

    logic [MBITS-1:0] staging_s;
    logic             commit_ok_s;
    logic [MBITS-1:0] active_r;
    logic [MBITS-1:0] lym_r;
    logic [MBITS-1:0] ly_s;

    assign ly_s = {ly5, ly4, ly3, ly2, ly1, ly0};

    hcm_loader u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .sdi       (mask_sdi),
        .shift     (mask_shift),
        .commit    (mask_commit),
        .err_clr   (err_clr),
        .staging   (staging_s),
        .commit_ok (commit_ok_s),
        .busy      (mask_busy),
        .err       (mask_err),
        .sdo       (mask_sdo)
    );

    // Active mask and masked hit register; the new mask gates hits from the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_r <= {MBITS{1'b1}};
            lym_r    <= {MBITS{1'b0}};
        end else begin
            if (commit_ok_s) begin
                active_r <= staging_s;
            end else begin
                active_r <= active_r;
            end
            lym_r <= ly_s & active_r;
        end
    end

    assign lym0 = lym_r[0*NW +: NW];
    assign lym1 = lym_r[1*NW +: NW];
    assign lym2 = lym_r[2*NW +: NW];
    assign lym3 = lym_r[3*NW +: NW];
    assign lym4 = lym_r[4*NW +: NW];
    assign lym5 = lym_r[5*NW +: NW];

endmodule
